ins_enco: RTL and testbench

- Instruction encoder/program loader: the write-side counterpart of the instruction decoder.
- Accepts a byte stream, typically from the UART receiver, and packs each instruction into a 16-bit word: {opcode[4:0], operand[10:0]}.
- Writes each word into program memory at consecutive addresses from 0, stopping at HLT.
- Opcode space matches the decoder: HLT=0, STO=1, LD=2, LDI=3, ADD=4, ADDI=5, SUB=6, SUBI=7.

---
 rtl/ins_enco_pkg.sv | 38 +++
 rtl/ins_enco_chk.sv | 17 +
 rtl/ins_enco.sv | 152 +++++++++++++++
 tb/tb_ins_enco.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_enco_pkg.sv
// ins_enco_pkg
// Shared definitions for the instruction encoder / program loader.
// The opcode table is the same one the instruction decoder uses, so both
// sides of the program path agree on which opcodes exist.
//   OPC_W / OPR_W : instruction word field widths
//   HLT..SUBI     : opcode values
//   ERR_*         : err_code values reported by the encoder
//   state_t       : encoder session state
package ins_enco_pkg;

    localparam int OPC_W = 5;
    localparam int OPR_W = 11;

    localparam logic [4:0] HLT  = 5'd0;
    localparam logic [4:0] STO  = 5'd1;
    localparam logic [4:0] LD   = 5'd2;
    localparam logic [4:0] LDI  = 5'd3;
    localparam logic [4:0] ADD  = 5'd4;
    localparam logic [4:0] ADDI = 5'd5;
    localparam logic [4:0] SUB  = 5'd6;
    localparam logic [4:0] SUBI = 5'd7;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OPC  = 2'b01;
    localparam logic [1:0] ERR_OPR  = 2'b10;
    localparam logic [1:0] ERR_FULL = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OPC   = 3'd1,
        OPH   = 3'd2,
        OPL   = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

endpackage

// File: rtl/ins_enco_chk.sv
// ins_enco_chk
// Combinational opcode-byte validator.
//   opc_byte      in  8  first byte of a frame
//   legal         out 1  upper bits clear and opcode within the decoder table
//   needs_operand out 1  frame carries two operand bytes (everything but HLT)
module ins_enco_chk
    import ins_enco_pkg::*;
(
    input  logic [7:0] opc_byte,
    output logic       legal,
    output logic       needs_operand
);

    assign legal         = (opc_byte[7:5] == 3'b000) && (opc_byte[4:0] <= SUBI);
    assign needs_operand = (opc_byte[4:0] != HLT);

endmodule

// File: rtl/ins_enco.sv
// ins_enco
// Instruction encoder / program loader. Packs a byte stream into
// {opcode, operand} words and writes them to program memory at consecutive
// addresses from 0 until HLT is written.
// Frame format: opcode byte, then (unless HLT) operand high byte holding
// operand[10:8] in bits [2:0], then operand low byte.
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse; starts a session (IDLE/DONE/ERR only)
//   in_byte/in_valid      byte stream; in_ready says a byte can be taken
//   pm_wr_en/pm_addr/pm_wr_data  program memory write port
//   busy/done/err/err_code       session status
//   instr_count           words written in the current session
//
// Handshake: a byte moves on a rising edge where in_valid && in_ready.
// in_valid may be held high while in_ready is low; nothing is consumed then.
module ins_enco #(
    parameter int OPC_W  = ins_enco_pkg::OPC_W,
    parameter int OPR_W  = ins_enco_pkg::OPR_W,
    parameter int ADDR_W = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   pm_wr_en,
    output logic [ADDR_W-1:0]      pm_addr,
    output logic [OPC_W+OPR_W-1:0] pm_wr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [ADDR_W:0]        instr_count
);
    import ins_enco_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    state_t state, state_nxt;

    logic               legal;
    logic               needs_operand;
    logic               xfer;
    logic               full;
    logic               opr_hi_bad;
    logic               word_is_hlt;
    logic [OPC_W-1:0]   opc_q;
    logic [OPR_W-9:0]   opr_hi_q;

    ins_enco_chk u_chk (
        .opc_byte      (in_byte),
        .legal         (legal),
        .needs_operand (needs_operand)
    );

    assign xfer       = in_valid && in_ready;
    // Last slot is kept for HLT, which also keeps pm_addr from ever wrapping.
    assign full       = (pm_addr == {ADDR_W{1'b1}});
    assign opr_hi_bad = (in_byte[7:OPR_W-8] != '0);
    // Only HLT packs to an all-zero opcode field.
    assign word_is_hlt = (pm_wr_data[OPC_W+OPR_W-1 -: OPC_W] == OPC_W'(HLT));

    // Status outputs are straight decodes of the state register.
    assign in_ready = (state == OPC) || (state == OPH) || (state == OPL);
    assign pm_wr_en = (state == WRITE);
    assign busy     = in_ready || pm_wr_en;
    assign done     = (state == DONE);
    assign err      = (state == ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) state_nxt = OPC;
            end
            OPC: begin
                if (xfer) begin
                    if (!legal)              state_nxt = ERR;
                    else if (!needs_operand) state_nxt = WRITE;
                    else if (full)           state_nxt = ERR;
                    else                     state_nxt = OPH;
                end
            end
            OPH: begin
                if (xfer) state_nxt = opr_hi_bad ? ERR : OPL;
            end
            OPL: begin
                if (xfer) state_nxt = WRITE;
            end
            WRITE: begin
                state_nxt = word_is_hlt ? DONE : OPC;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_addr     <= '0;
            instr_count <= '0;
            err_code    <= ERR_NONE;
            pm_wr_data  <= '0;
            opc_q       <= '0;
            opr_hi_q    <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        pm_addr     <= '0;
                        instr_count <= '0;
                        err_code    <= ERR_NONE;
                    end
                end
                OPC: begin
                    if (xfer) begin
                        if (!legal)              err_code   <= ERR_OPC;
                        else if (!needs_operand) pm_wr_data <= '0;
                        else if (full)           err_code   <= ERR_FULL;
                        else                     opc_q      <= in_byte[OPC_W-1:0];
                    end
                end
                OPH: begin
                    if (xfer) begin
                        if (opr_hi_bad) err_code <= ERR_OPR;
                        else            opr_hi_q <= in_byte[OPR_W-9:0];
                    end
                end
                OPL: begin
                    // Word is assembled only once complete, so an aborted
                    // frame never disturbs pm_wr_data.
                    if (xfer) pm_wr_data <= {opc_q, opr_hi_q, in_byte};
                end
                WRITE: begin
                    instr_count <= instr_count + CNT_ONE;
                    if (!word_is_hlt) pm_addr <= pm_addr + ADDR_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ins_enco.sv
// tb_ins_enco
// Bench for ins_enco. Two instances share stimulus: the default one
// (ADDR_W=11) and a small one (ADDR_W=2) for the memory-full boundary.
// sel_small chooses which instance the scoreboard and tasks observe.
module tb_ins_enco;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        sel_small;

    logic        b_in_ready, b_pm_wr_en, b_busy, b_done, b_err;
    logic [10:0] b_pm_addr;
    logic [15:0] b_pm_wr_data;
    logic [1:0]  b_err_code;
    logic [11:0] b_instr_count;

    logic        s_in_ready, s_pm_wr_en, s_busy, s_done, s_err;
    logic [1:0]  s_pm_addr;
    logic [15:0] s_pm_wr_data;
    logic [1:0]  s_err_code;
    logic [2:0]  s_instr_count;

    logic        in_ready_o, pm_wr_en_o, busy_o, done_o, err_o;
    logic [10:0] pm_addr_o;
    logic [15:0] pm_wr_data_o;
    logic [1:0]  err_code_o;
    logic [11:0] instr_count_o;

    logic [26:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        prev_wr  = 1'b0;

    ins_enco dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(b_in_ready), .pm_wr_en(b_pm_wr_en), .pm_addr(b_pm_addr),
        .pm_wr_data(b_pm_wr_data), .busy(b_busy), .done(b_done), .err(b_err),
        .err_code(b_err_code), .instr_count(b_instr_count)
    );

    ins_enco #(.ADDR_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(s_in_ready), .pm_wr_en(s_pm_wr_en), .pm_addr(s_pm_addr),
        .pm_wr_data(s_pm_wr_data), .busy(s_busy), .done(s_done), .err(s_err),
        .err_code(s_err_code), .instr_count(s_instr_count)
    );

    assign in_ready_o    = sel_small ? s_in_ready    : b_in_ready;
    assign pm_wr_en_o    = sel_small ? s_pm_wr_en    : b_pm_wr_en;
    assign busy_o        = sel_small ? s_busy        : b_busy;
    assign done_o        = sel_small ? s_done        : b_done;
    assign err_o         = sel_small ? s_err         : b_err;
    assign pm_addr_o     = sel_small ? {9'd0, s_pm_addr} : b_pm_addr;
    assign pm_wr_data_o  = sel_small ? s_pm_wr_data  : b_pm_wr_data;
    assign err_code_o    = sel_small ? s_err_code    : b_err_code;
    assign instr_count_o = sel_small ? {9'd0, s_instr_count} : b_instr_count;

    // Clock
    always #5 clk = ~clk;

    // Scoreboard: every write must match the head of exp_q and last one cycle.
    always @(negedge clk) begin
        logic [26:0] exp_w;
        if (pm_wr_en_o === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", pm_addr_o, pm_wr_data_o);
            end else begin
                exp_w = exp_q.pop_front();
                if (({pm_addr_o, pm_wr_data_o} !== exp_w) || prev_wr) begin
                    n_fail++;
                    $display("FAIL write: got addr=%h data=%h prev_wr=%b, required addr=%h data=%h prev_wr=0",
                             pm_addr_o, pm_wr_data_o, prev_wr, exp_w[26:16], exp_w[15:0]);
                end
            end
        end
        prev_wr = (pm_wr_en_o === 1'b1);
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns just after the transferring edge (posedge + 1).
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (in_ready_o !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_timeout: in_ready=%b after %0d cycles, required 1", in_ready_o, waited);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_byte  = 8'($urandom_range(0, 255));
    endtask

    // Tests
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00; sel_small = 1'b0;
        tick(2);
        n_checks++;
        if ({b_in_ready, b_pm_wr_en, b_pm_addr, b_pm_wr_data, b_busy, b_done, b_err, b_err_code, b_instr_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_big: got rdy=%b wr=%b addr=%h data=%h busy=%b done=%b err=%b code=%b cnt=%0d, required all 0",
                     b_in_ready, b_pm_wr_en, b_pm_addr, b_pm_wr_data, b_busy, b_done, b_err, b_err_code, b_instr_count);
        end
        n_checks++;
        if ({s_in_ready, s_pm_wr_en, s_pm_addr, s_pm_wr_data, s_busy, s_done, s_err, s_err_code, s_instr_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_small: outputs not all 0");
        end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_ldi_hlt();
        pulse_start();
        n_checks++;
        if (busy_o !== 1'b1 || in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL start_opc: busy=%b in_ready=%b, required 1 1", busy_o, in_ready_o);
        end
        exp_q.push_back({11'd0, 16'h182A});
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h2A);
        exp_q.push_back({11'd1, 16'h0000});
        send_byte(8'h00);
        tick(3);
        n_checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || err_o !== 1'b0 || in_ready_o !== 1'b0 ||
            instr_count_o !== 12'd2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ldi_hlt_done: done=%b busy=%b err=%b rdy=%b cnt=%0d pending=%0d, required 1 0 0 0 2 0",
                     done_o, busy_o, err_o, in_ready_o, instr_count_o, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        exp_q.push_back({11'd0, 16'h27FF});
        send_byte(8'h04); send_byte(8'h07); send_byte(8'hFF);
        n_checks++;
        if (pm_wr_en_o !== 1'b1 || in_ready_o !== 1'b0 || pm_addr_o !== 11'd0 || pm_wr_data_o !== 16'h27FF) begin
            n_fail++;
            $display("FAIL latency_wr0: wr=%b rdy=%b addr=%h data=%h, required 1 0 000 27ff",
                     pm_wr_en_o, in_ready_o, pm_addr_o, pm_wr_data_o);
        end
        @(posedge clk); #1;
        n_checks++;
        if (pm_wr_en_o !== 1'b0 || in_ready_o !== 1'b1 || pm_addr_o !== 11'd1 || instr_count_o !== 12'd1) begin
            n_fail++;
            $display("FAIL after_wr0: wr=%b rdy=%b addr=%h cnt=%0d, required 0 1 001 1",
                     pm_wr_en_o, in_ready_o, pm_addr_o, instr_count_o);
        end
        exp_q.push_back({11'd1, 16'h3005});
        send_byte(8'h06); send_byte(8'h00); send_byte(8'h05);
        n_checks++;
        if (pm_wr_en_o !== 1'b1 || in_ready_o !== 1'b0 || pm_wr_data_o !== 16'h3005) begin
            n_fail++;
            $display("FAIL latency_wr1: wr=%b rdy=%b data=%h, required 1 0 3005", pm_wr_en_o, in_ready_o, pm_wr_data_o);
        end
        @(posedge clk); #1;
        n_checks++;
        if (pm_wr_en_o !== 1'b0 || in_ready_o !== 1'b1 || pm_wr_data_o !== 16'h3005) begin
            n_fail++;
            $display("FAIL after_wr1: wr=%b rdy=%b data=%h, required 0 1 3005 held", pm_wr_en_o, in_ready_o, pm_wr_data_o);
        end
        exp_q.push_back({11'd2, 16'h0000});
        send_byte(8'h00);
        tick(3);
        n_checks++;
        if (done_o !== 1'b1 || instr_count_o !== 12'd3 || pm_addr_o !== 11'd2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b cnt=%0d addr=%h pending=%0d, required 1 3 002 0",
                     done_o, instr_count_o, pm_addr_o, exp_q.size());
        end
    endtask

    task automatic test_illegal_opc();
        pulse_start();
        send_byte(8'h09);
        @(negedge clk);
        n_checks++;
        if (err_o !== 1'b1 || err_code_o !== 2'b01 || busy_o !== 1'b0 || in_ready_o !== 1'b0 ||
            pm_addr_o !== 11'd0 || instr_count_o !== 12'd0) begin
            n_fail++;
            $display("FAIL illegal_opc: err=%b code=%b busy=%b rdy=%b addr=%h cnt=%0d, required 1 01 0 0 000 0",
                     err_o, err_code_o, busy_o, in_ready_o, pm_addr_o, instr_count_o);
        end
        tick(2);
        pulse_start();
        n_checks++;
        if (err_o !== 1'b0 || err_code_o !== 2'b00 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_clear: err=%b code=%b busy=%b, required 0 00 1", err_o, err_code_o, busy_o);
        end
        exp_q.push_back({11'd0, 16'h0000});
        send_byte(8'h00);
        tick(3);
        n_checks++;
        if (done_o !== 1'b1 || err_o !== 1'b0 || instr_count_o !== 12'd1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL recover_hlt: done=%b err=%b cnt=%0d pending=%0d, required 1 0 1 0",
                     done_o, err_o, instr_count_o, exp_q.size());
        end
    endtask

    task automatic test_operand_range();
        pulse_start();
        send_byte(8'h05); send_byte(8'h08);
        @(negedge clk);
        n_checks++;
        if (err_o !== 1'b1 || err_code_o !== 2'b10 || in_ready_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL operand_range: err=%b code=%b rdy=%b busy=%b, required 1 10 0 0",
                     err_o, err_code_o, in_ready_o, busy_o);
        end
        in_valid = 1'b1; in_byte = 8'h2A;
        tick(3);
        n_checks++;
        if (in_ready_o !== 1'b0 || err_code_o !== 2'b10 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL err_hold: rdy=%b code=%b pending=%0d, required 0 10 0", in_ready_o, err_code_o, exp_q.size());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mem_full();
        logic [10:0] opr;
        sel_small = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            pulse_start();
            for (int i = 0; i < 3; i++) begin
                opr = 11'($urandom_range(0, 2047));
                exp_q.push_back({11'(i), 5'd3, opr});
                send_byte(8'h03); send_byte({5'd0, opr[10:8]}); send_byte(opr[7:0]);
            end
            if (pass == 0) begin
                send_byte(8'h02);
                @(negedge clk);
                n_checks++;
                if (err_o !== 1'b1 || err_code_o !== 2'b11 || instr_count_o !== 12'd3 || pm_addr_o !== 11'd3) begin
                    n_fail++;
                    $display("FAIL mem_full: err=%b code=%b cnt=%0d addr=%h, required 1 11 3 003",
                             err_o, err_code_o, instr_count_o, pm_addr_o);
                end
                tick(2);
            end else begin
                exp_q.push_back({11'd3, 16'h0000});
                send_byte(8'h00);
                tick(3);
                n_checks++;
                if (done_o !== 1'b1 || err_o !== 1'b0 || instr_count_o !== 12'd4 || pm_addr_o !== 11'd3) begin
                    n_fail++;
                    $display("FAIL last_slot_hlt: done=%b err=%b cnt=%0d addr=%h, required 1 0 4 003",
                             done_o, err_o, instr_count_o, pm_addr_o);
                end
            end
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL mem_full_pending: %0d writes outstanding, required 0", exp_q.size());
            end
        end
        sel_small = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        pulse_start();
        send_byte(8'h02); send_byte(8'h01);
        in_valid = 1'b1; in_byte = 8'h2A;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({b_in_ready, b_pm_wr_en, b_pm_addr, b_pm_wr_data, b_busy, b_done, b_err, b_err_code, b_instr_count} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: rdy=%b wr=%b addr=%h data=%h busy=%b cnt=%0d, required all 0",
                     b_in_ready, b_pm_wr_en, b_pm_addr, b_pm_wr_data, b_busy, b_instr_count);
        end
        tick(3);
        n_checks++;
        if (in_ready_o !== 1'b0 || pm_wr_en_o !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_hold: rdy=%b wr=%b pending=%0d, required 0 0 0", in_ready_o, pm_wr_en_o, exp_q.size());
        end
        rst_n = 1'b1; in_valid = 1'b0;
        tick(1);
        pulse_start();
        exp_q.push_back({11'd0, 16'h1923});
        send_byte(8'h03); send_byte(8'h01); send_byte(8'h23);
        exp_q.push_back({11'd1, 16'h0000});
        send_byte(8'h00);
        tick(3);
        n_checks++;
        if (done_o !== 1'b1 || instr_count_o !== 12'd2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL post_reset_load: done=%b cnt=%0d pending=%0d, required 1 2 0",
                     done_o, instr_count_o, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_ldi_hlt();
        test_back_to_back();
        test_illegal_opc();
        test_operand_range();
        test_mem_full();
        test_reset_mid_frame();
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
